// File: rtl/nor_word_program_if.sv
// Host-side request/response and flash-pin bundle for the NOR word-program sequencer.
interface nor_word_program_if;
  logic        start;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [3:0]  err;
  logic [7:0]  status;
  logic        ce_n;
  logic        we_n;
  logic        oe_n;
  logic [23:0] addr;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [15:0] dq_in;

  modport master (
    output start, wr_addr, wr_data, dq_in,
    input  busy, done, err, status, ce_n, we_n, oe_n, addr, dq_out, dq_oe
  );

  modport slave (
    input  start, wr_addr, wr_data, dq_in,
    output busy, done, err, status, ce_n, we_n, oe_n, addr, dq_out, dq_oe
  );
endinterface

// File: rtl/nor_word_program.sv
// Single-word program sequencer for a 16-bit parallel NOR flash: unlock, program,
// poll status until ready, clear status on error, return to read-array mode.
module nor_word_program #(
  parameter int unsigned WE_CYC   = 6,
  parameter int unsigned RD_CYC   = 12,
  parameter int unsigned POLL_MAX = 4096
) (
  input logic               clk,
  input logic               reset,
  nor_word_program_if.slave bus_if
);

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CYC_MAX = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned PCNT_W  = $clog2(POLL_MAX + 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] W_SETUP = 4'd1;
  localparam logic [3:0] W_PULSE = 4'd2;
  localparam logic [3:0] W_HOLD  = 4'd3;
  localparam logic [3:0] W_GAP   = 4'd4;
  localparam logic [3:0] R_PULSE = 4'd5;
  localparam logic [3:0] R_END   = 4'd6;
  localparam logic [3:0] CHECK   = 4'd7;
  localparam logic [3:0] FINISH  = 4'd8;

  localparam logic [2:0] ST_UNLK = 3'd0;
  localparam logic [2:0] ST_CONF = 3'd1;
  localparam logic [2:0] ST_PSET = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_RSR  = 3'd4;
  localparam logic [2:0] ST_POLL = 3'd5;
  localparam logic [2:0] ST_CLR  = 3'd6;
  localparam logic [2:0] ST_RA   = 3'd7;

  logic [3:0]        state_q,  state_d;
  logic [2:0]        step_q,   step_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [PCNT_W-1:0] poll_q,   poll_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              ce_n_q,   ce_n_d;
  logic              we_n_q,   we_n_d;
  logic              oe_n_q,   oe_n_d;
  logic              dq_oe_q,  dq_oe_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [3:0]        err_q,    err_d;
  logic [7:0]        status_q, status_d;
  logic [3:0]        err_new;
  logic              timeout;
  logic [DATA_W-1:0] cmd;

  logic unused_dq_hi;
  assign unused_dq_hi = ^bus_if.dq_in[15:8];

  // Next-state, step sequencing, status sampling and registered pin values
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q + CNT_W'(1);
    poll_d   = poll_q;
    addr_d   = addr_q;
    data_d   = data_q;
    dq_out_d = dq_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    status_d = status_q;
    timeout  = ~status_q[7] && (poll_q == PCNT_W'(POLL_MAX));
    err_new  = {timeout, status_q[4], status_q[3], status_q[1]};
    cmd      = '0;

    case (state_q)
      IDLE: begin
        // a start coinciding with the done pulse is dropped
        if (bus_if.start && !done_q) begin
          addr_d  = bus_if.wr_addr;
          data_d  = bus_if.wr_data;
          step_d  = ST_UNLK;
          err_d   = '0;
          busy_d  = 1'b1;
          state_d = W_SETUP;
        end
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: if (cnt_q == CNT_W'(WE_CYC - 1)) state_d = W_HOLD;
      W_HOLD:  state_d = W_GAP;
      W_GAP: begin
        case (step_q)
          ST_RSR: begin
            step_d  = ST_POLL;
            poll_d  = '0;
            state_d = R_PULSE;
          end
          ST_CLR: begin
            step_d  = ST_RA;
            state_d = W_SETUP;
          end
          ST_RA:   state_d = FINISH;
          default: begin
            step_d  = step_q + 3'd1;
            state_d = W_SETUP;
          end
        endcase
      end
      R_PULSE: begin
        if (cnt_q == CNT_W'(RD_CYC - 1)) begin
          status_d = bus_if.dq_in[7:0];
          if (poll_q != PCNT_W'(POLL_MAX)) poll_d = poll_q + PCNT_W'(1);
          state_d = R_END;
        end
      end
      R_END: state_d = CHECK;
      CHECK: begin
        if (status_q[7] || timeout) begin
          err_d   = err_new;
          step_d  = (|err_new) ? ST_CLR : ST_RA;
          state_d = W_SETUP;
        end else begin
          state_d = R_PULSE;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    case (step_d)
      ST_UNLK: cmd = 16'h0060;
      ST_CONF: cmd = 16'h00D0;
      ST_PSET: cmd = 16'h0040;
      ST_DATA: cmd = data_d;
      ST_RSR:  cmd = 16'h0070;
      ST_CLR:  cmd = 16'h0050;
      ST_RA:   cmd = 16'h00FF;
      default: cmd = '0;
    endcase
    if (state_d == W_SETUP) dq_out_d = cmd;

    ce_n_d  = ~((state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == R_PULSE));
    we_n_d  = (state_d != W_PULSE);
    oe_n_d  = (state_d != R_PULSE);
    dq_oe_d = (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= ST_UNLK;
      cnt_q    <= '0;
      poll_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      dq_out_q <= '0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      poll_q   <= poll_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dq_out_q <= dq_out_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dq_oe_q  <= dq_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  assign bus_if.busy   = busy_q;
  assign bus_if.done   = done_q;
  assign bus_if.err    = err_q;
  assign bus_if.status = status_q;
  assign bus_if.ce_n   = ce_n_q;
  assign bus_if.we_n   = we_n_q;
  assign bus_if.oe_n   = oe_n_q;
  assign bus_if.addr   = addr_q;
  assign bus_if.dq_out = dq_out_q;
  assign bus_if.dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_nor_word_program.sv
// Directed bench for nor_word_program: a scripted status-register model answers
// reads, a monitor logs every completed write cycle and bus-rule violations.
module tb_nor_word_program;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nor_word_program_if bus ();

  nor_word_program #(
    .WE_CYC  (6),
    .RD_CYC  (12),
    .POLL_MAX(4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus)
  );

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          act_cnt  = 0;
  int          viol     = 0;
  int          addr_bad = 0;
  int          wr_base  = 0;
  int          rd_base  = 0;
  int          ab_base  = 0;
  int          sr_len   = 1;
  logic [23:0] exp_addr = '0;
  logic        prev_we  = 1'b1;
  logic        prev_oe  = 1'b1;
  logic [15:0] wlog    [256];
  logic [15:0] exp_wr  [8];
  logic [7:0]  sr_seq  [8];
  logic [7:0]  sr_cur;

  // Status model: k-th read of the current transaction returns sr_seq[k], last entry repeats
  always_comb begin
    int k;
    k = rd_cnt - rd_base;
    if (k >= sr_len) k = sr_len - 1;
    if (k < 0) k = 0;
    sr_cur = sr_seq[k[2:0]];
  end
  assign bus.dq_in = {8'h3C, sr_cur};

  always @(negedge clk) begin
    if (!bus.we_n && !bus.oe_n) viol++;
    if (bus.dq_oe && !bus.oe_n) viol++;
    if (!prev_we && bus.we_n) begin
      if (!bus.dq_oe || bus.addr !== exp_addr) addr_bad++;
      wlog[wr_cnt % 256] = bus.dq_out;
      wr_cnt++;
    end
    if (!prev_oe && bus.oe_n) rd_cnt++;
    if (!bus.ce_n) act_cnt++;
    prev_we = bus.we_n;
    prev_oe = bus.oe_n;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input int n);
    check_eq("n_writes", wr_cnt - wr_base, n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("wr%0d", i), {16'h0, wlog[(wr_base + i) % 256]}, {16'h0, exp_wr[i]});
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [15:0] d, input bit poke,
                         output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    wr_base  = wr_cnt;
    rd_base  = rd_cnt;
    ab_base  = addr_bad;
    exp_addr = a;
    @(negedge clk);
    bus.start = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_addr = ~a; bus.wr_data = ~d;
    check_eq("busy_rise", bus.busy, 1);
    check_eq("err_clr", bus.err, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (poke) bus.start = (i == 20);
      if (bus.done) begin
        got = 1'b1;
        lat = i + 1;
        break;
      end
    end
    check_eq("done_seen", got, 1);
    bus.start = poke;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("done_1cyc", bus.done, 0);
    check_eq("busy_drop", bus.busy, 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      check_eq("start_in_done", bus.busy, 0);
    end
    check_eq("wr_addr", addr_bad - ab_base, 0);
  endtask

  initial begin
    int  lat;
    int  wb;
    int  rb;
    int  ab;
    bit  hit;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int i = 0; i < 8; i++) sr_seq[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_ce_n", bus.ce_n, 1);
    check_eq("rst_we_n", bus.we_n, 1);
    check_eq("rst_oe_n", bus.oe_n, 1);
    check_eq("rst_addr", bus.addr, 0);
    check_eq("rst_dq_out", bus.dq_out, 0);
    check_eq("rst_dq_oe", bus.dq_oe, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_status", bus.status, 0);

    // Normal program, ready on first poll
    sr_seq[0] = 8'h80; sr_len = 1;
    run_txn(24'h3F0000, 16'hA5A5, 1'b0, lat);
    check_eq("norm_lat", lat, 69);
    check_eq("norm_err", bus.err, 4'b0000);
    check_eq("norm_status", bus.status, 8'h80);
    check_eq("norm_reads", rd_cnt - rd_base, 1);
    exp_wr = '{16'h0060, 16'h00D0, 16'h0040, 16'hA5A5, 16'h0070, 16'h00FF, 16'h0, 16'h0};
    chk_wr(6);

    // Busy polling, plus start pulses mid-sequence and in the done cycle
    sr_seq = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}; sr_len = 4;
    run_txn(24'h123456, 16'h1234, 1'b1, lat);
    check_eq("poll_lat", lat, 111);
    check_eq("poll_err", bus.err, 4'b0000);
    check_eq("poll_reads", rd_cnt - rd_base, 4);
    exp_wr = '{16'h0060, 16'h00D0, 16'h0040, 16'h1234, 16'h0070, 16'h00FF, 16'h0, 16'h0};
    chk_wr(6);

    // Program error
    sr_seq[0] = 8'h90; sr_len = 1;
    run_txn(24'h000001, 16'hFFFE, 1'b0, lat);
    check_eq("perr_lat", lat, 78);
    check_eq("perr_err", bus.err, 4'b0100);
    check_eq("perr_status", bus.status, 8'h90);
    exp_wr = '{16'h0060, 16'h00D0, 16'h0040, 16'hFFFE, 16'h0070, 16'h0050, 16'h00FF, 16'h0};
    chk_wr(7);

    // Locked block
    sr_seq[0] = 8'h82; sr_len = 1;
    run_txn(24'hFFFFFF, 16'h0000, 1'b0, lat);
    check_eq("lock_err", bus.err, 4'b0001);
    check_eq("lock_status", bus.status, 8'h82);
    exp_wr = '{16'h0060, 16'h00D0, 16'h0040, 16'h0000, 16'h0070, 16'h0050, 16'h00FF, 16'h0};
    chk_wr(7);

    // Timeout after POLL_MAX reads of a never-ready device
    sr_seq[0] = 8'h00; sr_len = 1;
    run_txn(24'h0A0B0C, 16'h5A5A, 1'b0, lat);
    check_eq("to_lat", lat, 120);
    check_eq("to_err", bus.err, 4'b1000);
    check_eq("to_status", bus.status, 8'h00);
    check_eq("to_reads", rd_cnt - rd_base, 4);
    exp_wr = '{16'h0060, 16'h00D0, 16'h0040, 16'h5A5A, 16'h0070, 16'h0050, 16'h00FF, 16'h0};
    chk_wr(7);

    // Reset during the data-word write pulse
    sr_seq[0] = 8'h80; sr_len = 1;
    wr_base  = wr_cnt;
    rd_base  = rd_cnt;
    exp_addr = 24'h222222;
    hit      = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.wr_addr = 24'h222222; bus.wr_data = 16'hBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((wr_cnt - wr_base == 3) && !bus.we_n) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("rst_hit", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_ce_n", bus.ce_n, 1);
    check_eq("mid_we_n", bus.we_n, 1);
    check_eq("mid_oe_n", bus.oe_n, 1);
    check_eq("mid_dq_oe", bus.dq_oe, 0);
    check_eq("mid_busy", bus.busy, 0);
    @(negedge clk);
    wb = wr_cnt;
    rb = rd_cnt;
    ab = act_cnt;
    repeat (100) @(negedge clk);
    check_eq("mid_no_wr", wr_cnt - wb, 0);
    check_eq("mid_no_rd", rd_cnt - rb, 0);
    check_eq("mid_no_ce", act_cnt - ab, 0);
    check_eq("mid_busy_idle", bus.busy, 0);

    check_eq("bus_excl", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
